// File: rtl/tdc_multi.sv
// Multi-channel gated TDC: per-channel first/last hit timestamps and saturating hit counts,
// emitted as one AXI-Stream packet per gate period.
module tdc_multi #(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned HIT_WIDTH     = 8,
  parameter int unsigned CH_WIDTH      = 1 + HIT_WIDTH + 2 * COUNTER_WIDTH,
  parameter int unsigned DATA_WIDTH    = 2 + COUNTER_WIDTH + NUM_CH * CH_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_s0,
  input  logic [NUM_CH-1:0]     i_s,
  input  logic [NUM_CH-1:0]     i_ch_en,
  output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
  output logic                  o_m_axis_tvalid,
  input  logic                  i_m_axis_tready
);

  localparam logic [COUNTER_WIDTH-1:0] CntMax = '1;
  localparam logic [COUNTER_WIDTH-1:0] CntOne = COUNTER_WIDTH'(1);
  localparam logic [HIT_WIDTH-1:0]     HitMax = '1;
  localparam logic [HIT_WIDTH-1:0]     HitOne = HIT_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

  // Stage-1 copies; all recording works from these.
  logic                     gate_q;
  logic [COUNTER_WIDTH-1:0] ts_q;
  logic [NUM_CH-1:0]        hit_q;
  logic                     ts_max;

  logic sat_q, sat_d;

  logic [NUM_CH-1:0]                    valid_q, valid_d, m_valid;
  logic [NUM_CH-1:0][COUNTER_WIDTH-1:0] t1_q, t1_d, m_t1;
  logic [NUM_CH-1:0][COUNTER_WIDTH-1:0] t2_q, t2_d, m_t2;
  logic [NUM_CH-1:0][HIT_WIDTH-1:0]     hits_q, hits_d, m_hits;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tvalid_q, tvalid_d;

  assign cnt_d  = i_s0 ? '0 : ((cnt_q == CntMax) ? cnt_q : cnt_q + CntOne);
  assign ts_max = (ts_q == CntMax);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      gate_q <= 1'b0;
      ts_q   <= '0;
      hit_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      gate_q <= i_s0;
      ts_q   <= cnt_q;
      hit_q  <= i_s & i_ch_en;
    end
  end

  always_comb begin
    // Recorder contents with this cycle's hit folded in; used both for normal recording and
    // for the closing packet when the hit coincides with the gate.
    m_valid = valid_q;
    m_t1    = t1_q;
    m_t2    = t2_q;
    m_hits  = hits_q;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (hit_q[n]) begin
        m_valid[n] = 1'b1;
        m_t1[n]    = valid_q[n] ? t1_q[n] : ts_q;
        m_t2[n]    = ts_q;
        m_hits[n]  = (hits_q[n] == HitMax) ? hits_q[n] : hits_q[n] + HitOne;
      end
    end

    valid_d  = m_valid;
    t1_d     = m_t1;
    t2_d     = m_t2;
    hits_d   = m_hits;
    sat_d    = sat_q | ts_max;
    data_d   = data_q;
    tvalid_d = tvalid_q & ~i_m_axis_tready;

    if (gate_q) begin
      valid_d  = '0;
      t1_d     = '0;
      t2_d     = '0;
      hits_d   = '0;
      sat_d    = 1'b0;
      tvalid_d = 1'b1;
      data_d[COUNTER_WIDTH-1:0] = ts_q;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        data_d[COUNTER_WIDTH + n * CH_WIDTH +: CH_WIDTH] = {m_valid[n], m_hits[n], m_t2[n], m_t1[n]};
      end
      // Pending packet not taken this cycle is being overwritten.
      data_d[DATA_WIDTH-2] = tvalid_q & ~i_m_axis_tready;
      data_d[DATA_WIDTH-1] = sat_q | ts_max;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sat_q    <= 1'b0;
      valid_q  <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      hits_q   <= '0;
      data_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      sat_q    <= sat_d;
      valid_q  <= valid_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      hits_q   <= hits_d;
      data_q   <= data_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign o_m_axis_tdata  = data_q;
  assign o_m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_tdc_multi.sv
// Directed bench for tdc_multi: table of gate periods plus hand-written handshake,
// back-to-back gate and mid-period reset sequences.
module tb_tdc_multi;

  localparam int unsigned CW  = 8;
  localparam int unsigned NCH = 2;
  localparam int unsigned HW  = 2;
  localparam int unsigned CHW = 1 + HW + 2 * CW;
  localparam int unsigned DW  = 2 + CW + NCH * CHW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s0 = 1'b0;
  logic [1:0]    s = 2'b00;
  logic [1:0]    en = 2'b11;
  logic          rdy = 1'b1;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic [1:0]    p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdc_multi #(
    .COUNTER_WIDTH(CW),
    .NUM_CH       (NCH),
    .HIT_WIDTH    (HW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_s0           (s0),
    .i_s            (s),
    .i_ch_en        (en),
    .o_m_axis_tdata (tdata),
    .o_m_axis_tvalid(tvalid),
    .i_m_axis_tready(rdy)
  );

  // ch fields are {valid, hits, t2 (last), t1 (first)}
  function automatic logic [DW-1:0] pkt(
    input logic ovf, input logic drop,
    input logic v1, input logic [HW-1:0] h1, input logic [CW-1:0] l1, input logic [CW-1:0] f1,
    input logic v0, input logic [HW-1:0] h0, input logic [CW-1:0] l0, input logic [CW-1:0] f0,
    input logic [CW-1:0] t0);
    return {ovf, drop, v1, h1, l1, f1, v0, h0, l0, f0, t0};
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chk_pkt(input string nm, input logic [DW-1:0] exp);
    total++;
    if (tdata !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, tdata, exp);
    end
  endtask

  // Drive one cycle's inputs, advance to 1 time unit after the next rising edge.
  task automatic step(input logic g, input logic [1:0] pulses);
    s0 = g;
    s  = pulses;
    @(posedge clk);
    #1;
    s0 = 1'b0;
    s  = 2'b00;
  endtask

  typedef struct {
    int            len;
    logic [1:0]    en;
    int            c0_at;
    int            c0_n;
    int            c0_step;
    int            c1_at;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt[9];

  initial begin
    // Cycle k of a period has timestamp k-1; the gate sits at k = len.
    vt[0] = '{50,  2'b11, 0,   0, 1,  0,   pkt(0, 0, 0, 0, 0,   0,   0, 0, 0,   0,  49)};
    vt[1] = '{100, 2'b11, 10,  2, 30, 0,   pkt(0, 0, 0, 0, 0,   0,   1, 2, 39,  9,  99)};
    vt[2] = '{100, 2'b11, 0,   0, 1,  100, pkt(0, 0, 1, 1, 99,  99,  0, 0, 0,   0,  99)};
    vt[3] = '{100, 2'b11, 0,   0, 1,  0,   pkt(0, 0, 0, 0, 0,   0,   0, 0, 0,   0,  99)};
    vt[4] = '{300, 2'b11, 280, 1, 1,  0,   pkt(1, 0, 0, 0, 0,   0,   1, 1, 255, 255, 255)};
    vt[5] = '{100, 2'b11, 0,   0, 1,  0,   pkt(0, 0, 0, 0, 0,   0,   0, 0, 0,   0,  99)};
    vt[6] = '{100, 2'b11, 20,  6, 5,  0,   pkt(0, 0, 0, 0, 0,   0,   1, 3, 44,  19, 99)};
    vt[7] = '{100, 2'b10, 20,  6, 5,  50,  pkt(0, 0, 1, 1, 49,  49,  0, 0, 0,   0,  99)};
    vt[8] = '{60,  2'b11, 5,   1, 1,  59,  pkt(0, 0, 1, 1, 58,  58,  1, 1, 4,   4,  59)};

    @(posedge clk);
    #1;
    chk_bit("reset_tvalid", tvalid, 1'b0);
    chk_pkt("reset_tdata", '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      en = vt[i].en;
      for (int k = (i == 0) ? 1 : 3; k <= vt[i].len; k++) begin
        p = 2'b00;
        if (k >= vt[i].c0_at && k < vt[i].c0_at + vt[i].c0_n * vt[i].c0_step &&
            (k - vt[i].c0_at) % vt[i].c0_step == 0) p[0] = 1'b1;
        if (k == vt[i].c1_at) p[1] = 1'b1;
        step(k == vt[i].len, p);
      end
      chk_bit($sformatf("v%0d_load_cycle_tvalid", i), tvalid, 1'b0);
      step(1'b0, 2'b00);
      chk_bit($sformatf("v%0d_tvalid", i), tvalid, 1'b1);
      chk_pkt($sformatf("v%0d_tdata", i), vt[i].exp);
      step(1'b0, 2'b00);
    end

    // Overwrite: two gates with tready low, then tready high only in the third load cycle.
    en  = 2'b11;
    rdy = 1'b0;
    for (int k = 3; k < 20; k++) step(1'b0, 2'b00);
    step(1'b1, 2'b00);
    chk_bit("ovw_load_tvalid", tvalid, 1'b0);
    step(1'b0, 2'b00);
    chk_bit("ovw_p1_tvalid", tvalid, 1'b1);
    chk_pkt("ovw_p1_tdata", pkt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 19));
    for (int k = 2; k < 30; k++) step(1'b0, 2'b00);
    chk_pkt("ovw_p1_stable", pkt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 19));
    step(1'b1, 2'b00);
    chk_pkt("ovw_p1_hold_load", pkt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 19));
    step(1'b0, 2'b00);
    chk_bit("ovw_p2_tvalid", tvalid, 1'b1);
    chk_pkt("ovw_p2_drop", pkt(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 29));
    for (int k = 2; k < 10; k++) step(1'b0, 2'b00);
    step(1'b1, 2'b00);
    rdy = 1'b1;
    step(1'b0, 2'b00);
    rdy = 1'b0;
    chk_bit("ovw_p3_tvalid", tvalid, 1'b1);
    chk_pkt("ovw_p3_nodrop", pkt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9));
    step(1'b0, 2'b00);
    chk_bit("ovw_p3_held", tvalid, 1'b1);
    rdy = 1'b1;
    step(1'b0, 2'b00);
    chk_bit("ovw_p3_taken", tvalid, 1'b0);

    // Back-to-back gates.
    for (int k = 4; k < 15; k++) step(1'b0, 2'b00);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    chk_bit("b2b_p1_tvalid", tvalid, 1'b1);
    chk_pkt("b2b_p1_tdata", pkt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14));
    step(1'b0, 2'b00);
    chk_bit("b2b_p2_tvalid", tvalid, 1'b1);
    chk_pkt("b2b_p2_tdata", pkt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1'b0, 2'b00);
    chk_bit("b2b_idle_tvalid", tvalid, 1'b0);

    // Mid-period asynchronous reset with a packet pending and hits recorded.
    rdy = 1'b0;
    for (int k = 3; k < 10; k++) step(1'b0, (k == 5) ? 2'b01 : 2'b00);
    step(1'b1, 2'b00);
    step(1'b0, 2'b01);
    chk_bit("rst_pre_tvalid", tvalid, 1'b1);
    step(1'b0, 2'b10);
    #3;
    rst = 1'b1;
    #1;
    chk_bit("rst_async_tvalid", tvalid, 1'b0);
    chk_pkt("rst_async_tdata", '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy = 1'b1;
    for (int k = 1; k < 50; k++) step(1'b0, 2'b00);
    step(1'b1, 2'b00);
    chk_bit("rst_post_load_tvalid", tvalid, 1'b0);
    step(1'b0, 2'b00);
    chk_bit("rst_post_tvalid", tvalid, 1'b1);
    chk_pkt("rst_post_tdata", pkt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 49));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
